// File: rtl/keystream_gen_32.sv
// Galois-LFSR keystream generator: emits one 32-bit word per burst slot, one
// LFSR bit per clock, handed to the consumer over a valid/ready handshake.
module keystream_gen_32 #(
  parameter logic [31:0] POLY    = 32'h80200003,
  parameter int          COUNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_seed_load,
  input  logic [31:0]        i_seed,
  input  logic               i_start,
  input  logic [COUNT_W-1:0] i_num_words,
  output logic [31:0]        o_ks_word,
  output logic               o_ks_valid,
  input  logic               i_ks_ready,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {IDLE, GEN, HOLD, FIN} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [31:0]        r_lfsr;
  logic [31:0]        r_shift;
  logic [31:0]        r_ks_word;
  logic               r_ks_valid;
  logic [4:0]         r_bit_cnt;
  logic [COUNT_W-1:0] r_word_cnt;
  logic [COUNT_W-1:0] r_num_words;

  logic               w_bit;
  logic [31:0]        w_lfsr_next;
  logic [31:0]        w_shift_next;
  logic               w_handshake;
  logic [COUNT_W:0]   w_word_cnt_inc;
  logic               w_last_word;

  assign w_bit       = r_lfsr[0];
  assign w_lfsr_next = (r_lfsr >> 1) ^ (w_bit ? POLY : 32'h0);
  assign w_handshake = r_ks_valid & i_ks_ready;

  // Extra bit keeps the end-of-burst compare exact even at the maximum count.
  assign w_word_cnt_inc = {1'b0, r_word_cnt} + {{COUNT_W{1'b0}}, 1'b1};
  assign w_last_word    = (w_word_cnt_inc == {1'b0, r_num_words});

  assign o_ks_word  = r_ks_word;
  assign o_ks_valid = r_ks_valid;

  always_comb begin
    w_shift_next            = r_shift;
    w_shift_next[r_bit_cnt] = w_bit;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_next_state = (i_num_words != '0) ? GEN : FIN;
      end
      GEN: begin
        o_busy = 1'b1;
        if (r_bit_cnt == 5'd31) w_next_state = HOLD;
      end
      HOLD: begin
        o_busy = 1'b1;
        if (w_handshake) w_next_state = w_last_word ? FIN : GEN;
      end
      FIN: begin
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // A zero seed would lock the LFSR at zero forever, so it is replaced by 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr      <= 32'h00000001;
      r_shift     <= '0;
      r_ks_word   <= '0;
      r_ks_valid  <= 1'b0;
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_num_words <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_seed_load) r_lfsr <= (i_seed == 32'h0) ? 32'h00000001 : i_seed;
          if (i_start) begin
            r_num_words <= i_num_words;
            r_word_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
          end
        end
        GEN: begin
          r_lfsr    <= w_lfsr_next;
          r_shift   <= w_shift_next;
          r_bit_cnt <= r_bit_cnt + 5'd1;
          if (r_bit_cnt == 5'd31) begin
            r_ks_word  <= w_shift_next;
            r_ks_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (w_handshake) begin
            r_ks_valid <= 1'b0;
            r_word_cnt <= r_word_cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keystream_gen_32.sv
// Bench for keystream_gen_32: table-driven bursts, hand-written corner cases
// and random bursts, all compared against a bit-serial Galois LFSR model.
module tb_keystream_gen_32;

  localparam logic [31:0] POLY = 32'h80200003;

  logic        clock = 1'b0;
  logic        reset;
  logic        seedLoad;
  logic [31:0] seed;
  logic        start;
  logic [15:0] numWords;
  logic [31:0] ksWord;
  logic        ksValid;
  logic        ksReady;
  logic        busy;
  logic        done;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] modelLfsr;

  typedef struct {
    logic [31:0] seed;
    int          numWords;
    int          stall;
    bit          disturb;
    bit          checkLow;
    logic [7:0]  expLow;
  } vec_t;

  vec_t vectors[5];

  keystream_gen_32 dut (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_seed_load (seedLoad),
    .i_seed      (seed),
    .i_start     (start),
    .i_num_words (numWords),
    .o_ks_word   (ksWord),
    .o_ks_valid  (ksValid),
    .i_ks_ready  (ksReady),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference keystream: 32 Galois steps, collecting the shifted-out bit LSB first.
  task automatic modelWord(output logic [31:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      b = modelLfsr[0];
      w[i] = b;
      modelLfsr = (modelLfsr >> 1) ^ (b ? POLY : 32'h0);
    end
  endtask

  task automatic pulseJunk();
    seedLoad = 1'b1;
    start    = 1'b1;
    seed     = $urandom;
    numWords = 16'($urandom_range(4, 9));
  endtask

  task automatic clearJunk();
    seedLoad = 1'b0;
    start    = 1'b0;
  endtask

  // Entered and left on a falling edge; runs one complete burst of n >= 1 words.
  task automatic applyStimulus(input logic [31:0] s, input bit doSeed, input int n,
                               input int stall, input bit disturb,
                               input bit checkLow, input logic [7:0] expLow);
    logic [31:0] expWord;
    int k;
    if (doSeed) modelLfsr = (s == 32'h0) ? 32'h1 : s;
    seedLoad = doSeed;
    seed     = s;
    start    = 1'b1;
    numWords = 16'(n);
    ksReady  = (stall == 0);
    @(posedge clock); @(negedge clock);
    clearJunk();
    seed     = $urandom;
    numWords = 16'($urandom);
    checkOutput("busy after start", 32'(busy), 32'd1);
    for (int w = 0; w < n; w++) begin
      modelWord(expWord);
      k = 0;
      while (!ksValid && k < 40) begin
        if (disturb && k == 10) pulseJunk();
        @(posedge clock); k++;
        @(negedge clock);
        clearJunk();
      end
      checkOutput("word latency", 32'(k), 32'd32);
      if (!ksValid) begin
        ksReady = 1'b0;
        return;
      end
      checkOutput("ks_word", ksWord, expWord);
      if (w == 0 && checkLow) checkOutput("ks_word[7:0]", 32'(ksWord[7:0]), 32'(expLow));
      for (int j = 0; j < stall; j++) begin
        ksReady = 1'b0;
        if (disturb && j == 0) pulseJunk();
        @(posedge clock); @(negedge clock);
        clearJunk();
        checkOutput("stall ks_word", ksWord, expWord);
        checkOutput("stall ks_valid", 32'(ksValid), 32'd1);
      end
      ksReady = 1'b1;
      @(posedge clock); @(negedge clock);
      ksReady = (stall == 0);
      checkOutput("ks_valid drop", 32'(ksValid), 32'd0);
      checkOutput("done after handshake", 32'(done), (w == n - 1) ? 32'd1 : 32'd0);
      checkOutput("busy after handshake", 32'(busy), (w == n - 1) ? 32'd0 : 32'd1);
    end
    @(posedge clock); @(negedge clock);
    checkOutput("done single pulse", 32'(done), 32'd0);
    checkOutput("idle busy", 32'(busy), 32'd0);
    ksReady = 1'b0;
  endtask

  initial begin
    logic [31:0] resetSeed;
    vectors[0] = '{32'h00000001, 1, 0,  1'b0, 1'b1, 8'hDB};
    vectors[1] = '{32'h00000000, 1, 0,  1'b0, 1'b1, 8'hDB};
    vectors[2] = '{32'h00000001, 3, 10, 1'b0, 1'b1, 8'hDB};
    vectors[3] = '{32'hDEADBEEF, 2, 3,  1'b1, 1'b0, 8'h00};
    vectors[4] = '{32'h12345678, 3, 1,  1'b0, 1'b0, 8'h00};

    reset = 1'b1; seedLoad = 1'b0; seed = '0; start = 1'b0; numWords = '0; ksReady = 1'b0;
    modelLfsr = 32'h1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset ks_word", ksWord, 32'h0);
    checkOutput("reset ks_valid", 32'(ksValid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 5; v++)
      applyStimulus(vectors[v].seed, 1'b1, vectors[v].numWords, vectors[v].stall,
                    vectors[v].disturb, vectors[v].checkLow, vectors[v].expLow);

    // Zero-length burst: straight to the done pulse, never busy.
    start = 1'b1; numWords = 16'd0;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    checkOutput("zero burst done", 32'(done), 32'd1);
    checkOutput("zero burst busy", 32'(busy), 32'd0);
    checkOutput("zero burst valid", 32'(ksValid), 32'd0);
    @(posedge clock); @(negedge clock);
    checkOutput("zero burst done clear", 32'(done), 32'd0);
    checkOutput("zero burst still idle", 32'(busy), 32'd0);
    applyStimulus(32'h0, 1'b0, 1, 2, 1'b0, 1'b0, 8'h00);

    // Reset in the middle of word generation, at bit 17.
    resetSeed = 32'hA5C3_0F1E;
    seedLoad = 1'b1; seed = resetSeed; start = 1'b1; numWords = 16'd2;
    @(posedge clock); @(negedge clock);
    clearJunk();
    repeat (17) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    checkOutput("midburst reset ks_word", ksWord, 32'h0);
    checkOutput("midburst reset ks_valid", 32'(ksValid), 32'd0);
    checkOutput("midburst reset busy", 32'(busy), 32'd0);
    checkOutput("midburst reset done", 32'(done), 32'd0);
    modelLfsr = 32'h1;
    applyStimulus(32'h0, 1'b0, 1, 0, 1'b0, 1'b1, 8'hDB);
    applyStimulus(resetSeed, 1'b1, 1, 0, 1'b0, 1'b0, 8'h00);

    for (int r = 0; r < 6; r++)
      applyStimulus($urandom, 1'($urandom_range(0, 1)), $urandom_range(1, 3),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 8'h00);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/keystream_gen_32.md
Name: keystream_gen_32

Overview:
- Sequential keystream generator built on a 32-bit Galois LFSR.
- Produces one 32-bit keystream word at a time, one LFSR bit per clock, over a valid/ready handshake.
- Sits directly upstream of the 32-bit XOR stage: ks_word drives its B operand while the data word drives A, forming the stream-cipher datapath.
- A host controller seeds the LFSR and requests a burst of N words.

Parameters:
- POLY, 32'h80200003, Galois feedback mask (taps 32,22,2,1; maximal length).
- COUNT_W, 16, width of word-count request and internal word counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- seed_load  input  1  load seed into LFSR (honoured only in IDLE).
- seed  input  32  LFSR seed value.
- start  input  1  begin burst (honoured only in IDLE).
- num_words  input  COUNT_W  words in burst, sampled when start is accepted.
- ks_word  output  32  keystream word.
- ks_valid  output  1  ks_word valid.
- ks_ready  input  1  consumer accepts ks_word.
- busy  output  1  high in GEN and HOLD.
- done  output  1  one-cycle pulse at end of burst.

Behaviour:
- Reset (sync, active-high, overrides everything, including mid-burst):
  - lfsr=32'h00000001, ks_word=0, ks_valid=0, busy=0, done=0.
  - Word and bit counters cleared; state=IDLE.
- Seed load:
  - In IDLE, seed_load=1 loads lfsr<=seed.
  - seed==0 loads 32'h00000001 instead (lock-up avoidance).
  - Ignored when busy.
- start:
  - In IDLE, start=1 latches num_words and clears counters.
  - If seed_load and start are both high in the same cycle, the burst uses the new seed.
  - Ignored when busy.
  - The LFSR is not reseeded between bursts; it continues from its current state.
- States: IDLE, GEN, HOLD, FIN.
  - IDLE --start & num_words!=0--> GEN.
  - IDLE --start & num_words==0--> FIN.
  - GEN: each cycle:
    - Output bit b=lfsr[0].
    - lfsr<=(lfsr>>1)^(b?POLY:0).
    - Word shift register collects b at bit position bit_cnt (LSB first).
    - bit_cnt increments from 0 to 31.
    - On bit_cnt==31: ks_word<=completed word, ks_valid<=1, state<=HOLD.
  - HOLD:
    - LFSR frozen; ks_word and ks_valid held stable while ks_ready=0.
    - On ks_valid&ks_ready: ks_valid<=0 and word_cnt++.
    - If word_cnt+1==latched num_words, go to FIN; otherwise go to GEN.
    - There is no GEN cycle overlapping HOLD, so the minimum spacing between words is 33 cycles.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Latency:
  - start sampled at edge T gives ks_valid=1 after edge T+32, visible in cycle T+33.
  - Final handshake at edge H gives done=1 in cycle H+1.
- ks_ready asserted while ks_valid=0 has no effect.
- busy=1 in GEN and HOLD; busy=0 in IDLE and FIN.
- The word counter never wraps: num_words is at most 2^COUNT_W-1, and the comparison uses the latched value.
- Changes on num_words or seed mid-burst have no effect.

Test Plan:
- Reset, seed_load with seed=32'h00000001, start with num_words=1, ks_ready=1 -> ks_valid rises 33 cycles after start, ks_word[7:0]=8'hDB, full word matches a software Galois model, done pulses once, busy returns 0.
- seed=0 loaded -> identical output to the seed=1 case (ks_word[7:0]=8'hDB).
- num_words=3, ks_ready held 0 for 10 cycles on each word -> ks_word stable during each stall, LFSR does not advance, three words equal to model words 0..2, done after the third handshake.
- num_words=0 with start -> no ks_valid, done=1 in the cycle after start, busy never asserted.
- start and seed_load pulsed while busy mid-burst -> both ignored, sequence unchanged against the model.
- rst asserted during GEN at bit 17 -> next cycle all outputs at reset values, lfsr=1; a new start with the same seed reproduces the first word exactly.
